// File: rtl/multicore_sched.sv
`default_nettype none
// ============================================================================
// multicore_sched : staggered core reset release + round-robin result arbiter
// Revision 1.0
// ============================================================================
module multicore_sched #(
  parameter int N_CORES = 21,
  parameter int DW      = 31,
  parameter int STAGGER = 25,
  parameter int IDW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [N_CORES-1:0]    core_rst,
  input  logic [N_CORES-1:0]    core_valid,
  input  logic [N_CORES*DW-1:0] core_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IDW-1:0]        out_core_id,
  output logic                  all_started,
  output logic [N_CORES-1:0]    overflow
);

  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rel;
  logic [IDW-1:0]   rel_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_HOLD;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // k_q is the most recently released core; a release happens on the edge
  // that leaves HOLD and on every STAGGER-th edge after that.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    rel_idx = '0;
    case (state_q)
      S_HOLD: begin
        rel     = 1'b1;
        rel_idx = '0;
      end
      S_RELEASE: begin
        if (cnt_q == CW'(STAGGER - 1)) begin
          rel     = 1'b1;
          rel_idx = k_q + IDW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    if (rel) begin
      k_d     = rel_idx;
      cnt_d   = '0;
      state_d = (rel_idx == IDW'(N_CORES - 1)) ? S_DONE : S_RELEASE;
    end
  end

  for (genvar j = 0; j < N_CORES; j++) begin : g_rst
    assign core_rst[j] = (state_q == S_HOLD) ||
                         ((state_q == S_RELEASE) && (k_q < IDW'(j)));
  end

  assign all_started = (state_q == S_DONE);

  logic [N_CORES-1:0] pend_q;
  logic [N_CORES-1:0] ovf_q;
  logic [DW-1:0]      slot_q [N_CORES];
  logic               out_valid_q;
  logic [DW-1:0]      out_data_q;
  logic [IDW-1:0]     out_id_q;
  logic [IDW-1:0]     last_grant_q;

  logic               free;
  logic               found;
  logic [IDW-1:0]     gnt_idx;
  logic [N_CORES-1:0] drain;
  logic [N_CORES-1:0] cap;

  assign free = !out_valid_q || out_ready;
  assign cap  = core_valid & ~core_rst;

  // Rotating search starting just after the last granted core.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_CORES; i++) begin
      int idx;
      idx = int'(last_grant_q) + 1 + i;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!found && pend_q[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign drain = (free && found) ? (N_CORES'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q       <= '0;
      ovf_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      last_grant_q <= IDW'(N_CORES - 1);
      for (int k = 0; k < N_CORES; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CORES; k++) begin
        if (cap[k]) begin
          // A pulse landing on the drain edge refills the slot instead of overflowing.
          if (!pend_q[k] || drain[k]) slot_q[k] <= core_data[k*DW +: DW];
          else                        ovf_q[k]  <= 1'b1;
          pend_q[k] <= 1'b1;
        end else if (drain[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
      if (free) begin
        out_valid_q <= found;
        if (found) begin
          out_data_q   <= slot_q[gnt_idx];
          out_id_q     <= gnt_idx;
          last_grant_q <= gnt_idx;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_core_id = out_id_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multicore_sched.sv
`default_nettype none
// ============================================================================
// tb_multicore_sched : directed vectors for stagger release and arbitration
// Revision 1.0
// ============================================================================
module tb_multicore_sched;

  localparam int N   = 21;
  localparam int DW  = 31;
  localparam int ST  = 25;
  localparam int IDW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      core_rst;
  logic [N-1:0]      core_valid;
  logic [N*DW-1:0]   core_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_core_id;
  logic              all_started;
  logic [N-1:0]      overflow;

  multicore_sched #(.N_CORES(N), .DW(DW), .STAGGER(ST), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .core_rst(core_rst), .core_valid(core_valid),
    .core_data(core_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_core_id(out_core_id), .all_started(all_started),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] vld;
    int           dat;
    logic         rdy;
    logic         ev;
    int           ed;
    int           eid;
    logic [N-1:0] eov;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Core k presents dat + 1000*k so every core's word is distinguishable.
  task automatic drive(input logic [N-1:0] vld, input int dat);
    core_valid = vld;
    for (int k = 0; k < N; k++)
      core_data[k*DW +: DW] = vld[k] ? DW'(dat + k*1000) : '0;
  endtask

  task automatic add(input logic [N-1:0] vld, input int dat, input logic rdy,
                     input logic ev, input int ed, input int eid, input logic [N-1:0] eov);
    vec_t v;
    v = '{vld, dat, rdy, ev, ed, eid, eov};
    vq.push_back(v);
  endtask

  initial begin
    logic [N-1:0]  exp_rst;
    logic [DW-1:0] e31;

    // single result, round robin, backpressure, overflow, drain coincidence
    add(21'h8,    -3005, 1, 0, 0,     0,  21'h0);
    add(21'h0,    0,     1, 1, -5,    3,  21'h0);
    add(21'h0,    0,     1, 0, 0,     0,  21'h0);
    add(21'h80,   10,    1, 0, 0,     0,  21'h0);
    add(21'h0,    0,     1, 1, 7010,  7,  21'h0);
    add(21'h0,    0,     1, 0, 0,     0,  21'h0);
    add(21'h8084, 0,     1, 0, 0,     0,  21'h0);
    add(21'h0,    0,     1, 1, 15000, 15, 21'h0);
    add(21'h0,    0,     1, 1, 2000,  2,  21'h0);
    add(21'h0,    0,     1, 1, 7000,  7,  21'h0);
    add(21'h0,    0,     1, 0, 0,     0,  21'h0);
    add(21'h220,  1,     0, 0, 0,     0,  21'h0);
    add(21'h0,    0,     0, 1, 9001,  9,  21'h0);
    for (int i = 0; i < 10; i++) add(21'h0, 0, 0, 1, 9001, 9, 21'h0);
    add(21'h0,    0,     1, 1, 5001,  5,  21'h0);
    add(21'h0,    0,     1, 0, 0,     0,  21'h0);
    add(21'h2,    0,     0, 0, 0,     0,  21'h0);
    add(21'h10,   -3877, 0, 1, 1000,  1,  21'h0);
    add(21'h10,   -3001, 0, 1, 1000,  1,  21'h10);
    add(21'h0,    0,     1, 1, 123,   4,  21'h10);
    add(21'h0,    0,     1, 0, 0,     0,  21'h10);
    add(21'h40,   -5500, 0, 0, 0,     0,  21'h10);
    add(21'h40,   -5300, 0, 1, 500,   6,  21'h10);
    add(21'h0,    0,     1, 1, 700,   6,  21'h10);
    add(21'h0,    0,     1, 0, 0,     0,  21'h10);

    rst = 1'b0;
    out_ready = 1'b0;
    drive('0, 0);
    repeat (3) tick();
    chk("reset core_rst", 64'(core_rst), 64'({N{1'b1}}));
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_core_id", 64'(out_core_id), 64'd0);
    chk("reset all_started", 64'(all_started), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);

    rst = 1'b1;
    for (int e = 0; e <= (N-1)*ST; e++) begin
      tick();
      for (int j = 0; j < N; j++) exp_rst[j] = (e < j*ST);
      chk($sformatf("stagger core_rst edge %0d", e), 64'(core_rst), 64'(exp_rst));
      chk($sformatf("stagger all_started edge %0d", e), 64'(all_started), 64'(e >= (N-1)*ST));
    end

    foreach (vq[i]) begin
      drive(vq[i].vld, vq[i].dat);
      out_ready = vq[i].rdy;
      tick();
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vq[i].ev));
      if (vq[i].ev) begin
        e31 = DW'(vq[i].ed);
        chk($sformatf("vec%0d out_data", i), 64'(out_data), 64'(e31));
        chk($sformatf("vec%0d out_core_id", i), 64'(out_core_id), 64'(vq[i].eid));
      end
      chk($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vq[i].eov));
    end

    // mid-run reset with a word on the port and another pending
    drive(21'h3, 7);
    out_ready = 1'b0;
    tick();
    drive('0, 0);
    tick();
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    chk("pre-reset out_core_id", 64'(out_core_id), 64'd0);
    rst = 1'b0;
    tick();
    chk("midreset core_rst", 64'(core_rst), 64'({N{1'b1}}));
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset out_data", 64'(out_data), 64'd0);
    chk("midreset all_started", 64'(all_started), 64'd0);
    chk("midreset overflow", 64'(overflow), 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(21'h100000, 3);
    for (int e = 0; e <= ST; e++) begin
      tick();
      chk($sformatf("restart out_valid edge %0d", e), 64'(out_valid), 64'd0);
      chk($sformatf("restart core_rst[0] edge %0d", e), 64'(core_rst[0]), 64'd0);
      chk($sformatf("restart core_rst[1] edge %0d", e), 64'(core_rst[1]), 64'(e < ST));
    end

    // priority restarts at core 0 after reset
    drive(21'h3, 5);
    tick();
    chk("post-reset first out_valid", 64'(out_valid), 64'd0);
    drive('0, 0);
    tick();
    chk("post-reset grant0 valid", 64'(out_valid), 64'd1);
    chk("post-reset grant0 id", 64'(out_core_id), 64'd0);
    chk("post-reset grant0 data", 64'(out_data), 64'(DW'(5)));
    tick();
    chk("post-reset grant1 valid", 64'(out_valid), 64'd1);
    chk("post-reset grant1 id", 64'(out_core_id), 64'd1);
    chk("post-reset grant1 data", 64'(out_data), 64'(DW'(1005)));
    tick();
    chk("post-reset idle", 64'(out_valid), 64'd0);
    chk("post-reset overflow", 64'(overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
